sram_arbiter: RTL and testbench



---
 rtl/sram_arb_pkg.sv | 23 ++
 rtl/sram_rr_arbiter.sv | 39 +++
 rtl/sram_arbiter.sv | 169 ++++++++++++++++
 tb/tb_sram_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port asynchronous SRAM sequencer.
package sram_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_HOLD   = 2'd3
   } state_e;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DMA = 1'b1;

   localparam int CNT_W = 4;

   // Strobe width clamps to 1..15; the down-counter starts at width-1 and ends on zero.
   function automatic logic [CNT_W-1:0] wait_load(input int wait_cyc);
      int w;
      w = (wait_cyc < 1) ? 1 : ((wait_cyc > 15) ? 15 : wait_cyc);
      return CNT_W'(w - 1);
   endfunction

endpackage

// File: rtl/sram_rr_arbiter.sv
// Two-way round-robin grant; last_grant only advances when a grant is actually taken.
module sram_rr_arbiter
   import sram_arb_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] req,
   input  logic       grant_en,
   output logic [1:0] grant,
   output logic       grant_idx
);

   logic last_grant_q;
   logic last_grant_d;

   always_comb begin
      grant_idx    = PORT_CPU;
      grant        = 2'b00;
      last_grant_d = last_grant_q;
      if (req == 2'b11) begin
         grant_idx = ~last_grant_q;
      end else if (req[1]) begin
         grant_idx = PORT_DMA;
      end
      if (grant_en && (req != 2'b00)) begin
         grant        = (grant_idx == PORT_DMA) ? 2'b10 : 2'b01;
         last_grant_d = grant_idx;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_grant_q <= PORT_DMA;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

endmodule

// File: rtl/sram_arbiter.sv
// Sequencer for the external async 8-bit SRAM shared by the 6502 core and the loader DMA.
// All pin-side signals come straight from flops so strobes cannot glitch.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ST_IDLE   | chip deselected, pins released; arbitrate pending requests
//   ST_SETUP  | cen low, address (and write data) settling before the strobe
//   ST_ACCESS | wen or oen low for WAIT_CYC cycles; read data sampled at the end
//   ST_HOLD   | strobe released, cen and write data held; ack to the winner
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int AW       = 19,
   parameter int DW       = 8,
   parameter int WAIT_CYC = 2
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [1:0]      req,
   input  logic [1:0]      we,
   input  logic [2*AW-1:0] addr,
   input  logic [2*DW-1:0] wdata,
   output logic [1:0]      ack,
   output logic [DW-1:0]   rdata,
   output logic [AW-1:0]   sram_addr,
   output logic [DW-1:0]   sram_dout,
   input  logic [DW-1:0]   sram_din,
   output logic            sram_oe,
   output logic            sram_cen,
   output logic            sram_wen,
   output logic            sram_oen
);

   localparam logic [CNT_W-1:0] WAIT_LOAD = wait_load(WAIT_CYC);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             win_q, win_d;
   logic             we_q, we_d;
   logic [AW-1:0]    sram_addr_q, sram_addr_d;
   logic [DW-1:0]    sram_dout_q, sram_dout_d;
   logic [DW-1:0]    rdata_q, rdata_d;
   logic [1:0]       ack_q, ack_d;
   logic             oe_q, oe_d;
   logic             cen_q, cen_d;
   logic             wen_q, wen_d;
   logic             oen_q, oen_d;

   logic [1:0] grant;
   logic       grant_idx;
   logic       grant_en;

   assign grant_en = (state_q == ST_IDLE);

   sram_rr_arbiter u_rr (
      .clk       (clk),
      .reset_n   (reset_n),
      .req       (req),
      .grant_en  (grant_en),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      win_d       = win_q;
      we_d        = we_q;
      sram_addr_d = sram_addr_q;
      sram_dout_d = sram_dout_q;
      rdata_d     = rdata_q;
      ack_d       = 2'b00;
      oe_d        = oe_q;
      cen_d       = cen_q;
      wen_d       = wen_q;
      oen_d       = oen_q;

      unique case (state_q)
         ST_IDLE: begin
            cen_d = 1'b1;
            wen_d = 1'b1;
            oen_d = 1'b1;
            oe_d  = 1'b0;
            if (grant != 2'b00) begin
               win_d       = grant_idx;
               we_d        = we[grant_idx];
               sram_addr_d = grant_idx ? addr[2*AW-1:AW] : addr[AW-1:0];
               if (we[grant_idx]) begin
                  sram_dout_d = grant_idx ? wdata[2*DW-1:DW] : wdata[DW-1:0];
               end
               cen_d   = 1'b0;
               oe_d    = we[grant_idx];
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            cnt_d = WAIT_LOAD;
            if (we_q) begin
               wen_d = 1'b0;
            end else begin
               oen_d = 1'b0;
            end
            state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (cnt_q == '0) begin
               wen_d = 1'b1;
               oen_d = 1'b1;
               if (!we_q) begin
                  rdata_d = sram_din;
               end
               ack_d   = (win_q == PORT_DMA) ? 2'b10 : 2'b01;
               state_d = ST_HOLD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_HOLD: begin
            // Releasing oe together with cen gives the write-to-read turnaround its IDLE cycle.
            cen_d   = 1'b1;
            oe_d    = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         win_q       <= PORT_CPU;
         we_q        <= 1'b0;
         sram_addr_q <= '0;
         sram_dout_q <= '0;
         rdata_q     <= '0;
         ack_q       <= 2'b00;
         oe_q        <= 1'b0;
         cen_q       <= 1'b1;
         wen_q       <= 1'b1;
         oen_q       <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         win_q       <= win_d;
         we_q        <= we_d;
         sram_addr_q <= sram_addr_d;
         sram_dout_q <= sram_dout_d;
         rdata_q     <= rdata_d;
         ack_q       <= ack_d;
         oe_q        <= oe_d;
         cen_q       <= cen_d;
         wen_q       <= wen_d;
         oen_q       <= oen_d;
      end
   end

   assign ack       = ack_q;
   assign rdata     = rdata_q;
   assign sram_addr = sram_addr_q;
   assign sram_dout = sram_dout_q;
   assign sram_oe   = oe_q;
   assign sram_cen  = cen_q;
   assign sram_wen  = wen_q;
   assign sram_oen  = oen_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM device model, transaction-timeline reference model, directed and random traffic.
module tb_sram_arbiter;

   localparam int W  = 2;
   localparam int AW = 19;
   localparam int DW = 8;
   localparam int STARVE_LIM = 2 * (W + 3);

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
   logic [AW-1:0] addr0 = '0, addr1 = '0;
   logic [DW-1:0] wd0 = '0, wd1 = '0;

   logic [1:0]      req, we, ack;
   logic [2*AW-1:0] addr;
   logic [2*DW-1:0] wdata;
   logic [DW-1:0]   rdata, sram_dout;
   logic [DW-1:0]   sram_din = '0;
   logic [AW-1:0]   sram_addr;
   logic            sram_oe, sram_cen, sram_wen, sram_oen;

   assign req   = {req1, req0};
   assign we    = {we1, we0};
   assign addr  = {addr1, addr0};
   assign wdata = {wd1, wd0};

   sram_arbiter #(.AW(AW), .DW(DW), .WAIT_CYC(W)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req       (req),
      .we        (we),
      .addr      (addr),
      .wdata     (wdata),
      .ack       (ack),
      .rdata     (rdata),
      .sram_addr (sram_addr),
      .sram_dout (sram_dout),
      .sram_din  (sram_din),
      .sram_oe   (sram_oe),
      .sram_cen  (sram_cen),
      .sram_wen  (sram_wen),
      .sram_oen  (sram_oen)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- SRAM device model ----------------
   logic [DW-1:0] sram_mem [int];
   logic [DW-1:0] ref_mem  [int];

   function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
      return a[7:0] ^ 8'h96;
   endfunction

   function automatic logic [DW-1:0] dev_rd(input logic [AW-1:0] a);
      return sram_mem.exists(int'(a)) ? sram_mem[int'(a)] : dflt(a);
   endfunction

   function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
      return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : dflt(a);
   endfunction

   always @(posedge clk)
      if (reset_n && !sram_cen && !sram_wen && sram_oe) sram_mem[int'(sram_addr)] = sram_dout;

   always @(negedge clk) sram_din = dev_rd(sram_addr);

   // ---------------- reference model: one transaction on a timeline ----------------
   // m_ph counts clock edges since the grant edge: 1 setup, 2..W+1 strobe, W+2 ack.
   bit            m_act = 1'b0, m_win = 1'b0, m_we = 1'b0, m_last = 1'b1;
   int            m_ph = 0;
   logic [AW-1:0] m_saddr = '0;
   logic [DW-1:0] m_sdout = '0, m_rdata = '0, m_rval = '0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_act = 1'b0; m_ph = 0; m_last = 1'b1;
         m_rdata = '0; m_saddr = '0; m_sdout = '0;
      end else if (m_act) begin
         m_ph++;
         if (m_ph == W + 3) m_act = 1'b0;
         else if (m_ph == W + 2 && !m_we) m_rdata = m_rval;
      end else if (req0 || req1) begin
         m_win  = (req0 && req1) ? !m_last : req1;
         m_last = m_win;
         m_act  = 1'b1;
         m_ph   = 1;
         m_we   = m_win ? we1 : we0;
         m_saddr = m_win ? addr1 : addr0;
         if (m_we) begin
            m_sdout = m_win ? wd1 : wd0;
            ref_mem[int'(m_saddr)] = m_sdout;
         end else begin
            m_rval = ref_rd(m_saddr);
         end
      end
   end

   // ---------------- per-cycle compare + turnaround monitor ----------------
   int ncyc = 0, last_oe_cyc = -1000, last_oen_cyc = -1000;
   int min_wr_rd_gap = 1000, min_rd_wr_gap = 1000;
   logic prev_oe = 1'b0, prev_oen = 1'b1;

   always @(negedge clk) begin
      logic [40:0] exp_v, act_v;
      logic        in_acc;
      logic [1:0]  exp_ack;
      in_acc  = m_act && m_ph >= 2 && m_ph <= W + 1;
      exp_ack = (m_act && m_ph == W + 2) ? (m_win ? 2'b10 : 2'b01) : 2'b00;
      exp_v = {!m_act, !(in_acc && m_we), !(in_acc && !m_we), m_act && m_we,
               exp_ack, m_saddr, m_sdout, m_rdata};
      act_v = {sram_cen, sram_wen, sram_oen, sram_oe, ack, sram_addr, sram_dout, rdata};
      chk("model_outputs{cen,wen,oen,oe,ack,addr,dout,rdata}", act_v, exp_v);
      chk("oe_with_oen_low", sram_oe & ~sram_oen, 1'b0);
      chk("ack_both", ack == 2'b11, 1'b0);

      ncyc++;
      if (!sram_oen && prev_oen && (ncyc - last_oe_cyc - 1) < min_wr_rd_gap)
         min_wr_rd_gap = ncyc - last_oe_cyc - 1;
      if (sram_oe && !prev_oe && (ncyc - last_oen_cyc - 1) < min_rd_wr_gap)
         min_rd_wr_gap = ncyc - last_oen_cyc - 1;
      if (sram_oe) last_oe_cyc = ncyc;
      if (!sram_oen) last_oen_cyc = ncyc;
      prev_oe  = sram_oe;
      prev_oen = sram_oen;
   end

   task automatic wait_ack(input int p, input int lim, output int n);
      n = -1;
      for (int i = 1; i <= lim; i++) begin
         @(negedge clk);
         if (ack[p]) begin
            n = i;
            break;
         end
      end
   endtask

   int n, cnt0, cnt1;
   int ack_log[$];
   bit stop;

   initial begin
      sram_mem[int'(19'h7FFFF)] = 8'h3C;
      ref_mem[int'(19'h7FFFF)]  = 8'h3C;
      repeat (3) @(negedge clk);
      chk("reset_strobes{cen,wen,oen,oe}", {sram_cen, sram_wen, sram_oen, sram_oe}, 4'b1110);
      chk("reset_ack_rdata", {ack, rdata}, 10'h000);
      reset_n = 1'b1;
      @(negedge clk);

      // Port 0 write, literal timeline
      we0 = 1'b1; addr0 = 19'h00123; wd0 = 8'hA5; req0 = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         chk($sformatf("t1_wen_c%0d", k), sram_wen, !(k == 2 || k == 3));
         chk($sformatf("t1_oe_c%0d", k), sram_oe, k <= 4);
         chk($sformatf("t1_ack0_c%0d", k), ack[0], k == 4);
         if (k <= 4) chk("t1_addr", sram_addr, 19'h00123);
         if (k == 4) req0 = 1'b0;
      end
      chk("t1_mem", dev_rd(19'h00123), 8'hA5);

      // Port 1 read of top address; request dropped mid-transaction
      we1 = 1'b0; addr1 = 19'h7FFFF; req1 = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (k == 2) req1 = 1'b0;
         chk($sformatf("t2_oen_c%0d", k), sram_oen, !(k == 2 || k == 3));
         chk($sformatf("t2_oe_c%0d", k), sram_oe, 1'b0);
         chk($sformatf("t2_ack1_c%0d", k), ack[1], k == 4);
         if (k >= 4) chk("t2_rdata", rdata, 8'h3C);
      end

      // Both ports at once, four times each
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      cnt0 = 0; cnt1 = 0;
      we0 = 1'b1; addr0 = 19'h00040; wd0 = 8'h01; req0 = 1'b1;
      we1 = 1'b0; addr1 = 19'h00041; req1 = 1'b1;
      for (int i = 0; i < 80 && (cnt0 < 4 || cnt1 < 4); i++) begin
         @(negedge clk);
         if (ack[0]) begin
            ack_log.push_back(0); cnt0++;
            if (cnt0 < 4) begin addr0 = addr0 + 1'b1; wd0 = wd0 + 1'b1; end else req0 = 1'b0;
         end
         if (ack[1]) begin
            ack_log.push_back(1); cnt1++;
            if (cnt1 < 4) addr1 = addr1 + 1'b1; else req1 = 1'b0;
         end
      end
      chk("t3_ack_count", ack_log.size(), 8);
      for (int i = 0; i < ack_log.size() && i < 8; i++)
         chk($sformatf("t3_grant_order_%0d", i), ack_log[i], i % 2);

      // Write then immediate read of same address
      we0 = 1'b1; addr0 = 19'h00010; wd0 = 8'h5A; req0 = 1'b1;
      wait_ack(0, STARVE_LIM, n);
      chk("t4_wr_ack_seen", n > 0, 1'b1);
      req0 = 1'b0;
      we1 = 1'b0; addr1 = 19'h00010; req1 = 1'b1;
      wait_ack(1, STARVE_LIM, n);
      chk("t4_rd_ack_seen", n > 0, 1'b1);
      req1 = 1'b0;
      chk("t4_rdata", rdata, 8'h5A);
      @(negedge clk);

      // Reset during write access
      we0 = 1'b1; addr0 = 19'h00200; wd0 = 8'h11; req0 = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("t5_rst_cen", sram_cen, 1'b1);
      chk("t5_rst_wen", sram_wen, 1'b1);
      chk("t5_rst_oe", sram_oe, 1'b0);
      repeat (3) begin
         @(negedge clk);
         chk("t5_no_ack", ack, 2'b00);
      end
      #2 reset_n = 1'b1;
      wait_ack(0, STARVE_LIM, n);
      chk("t5_rerun_ack_latency", n, W + 2);
      req0 = 1'b0;
      chk("t5_mem", dev_rd(19'h00200), 8'h11);
      @(negedge clk);

      // Port 0 hogging, port 1 must still get through
      stop = 1'b0;
      we0 = 1'b0; addr0 = 19'h00300; req0 = 1'b1;
      fork
         begin
            while (!stop) begin
               @(negedge clk);
               if (ack[0]) addr0 = addr0 + 1'b1;
            end
            req0 = 1'b0;
         end
         begin
            wait_ack(0, STARVE_LIM, n);
            chk("t6_hog_ack_seen", n > 0, 1'b1);
            @(negedge clk);
            @(negedge clk);
            we1 = 1'b1; addr1 = 19'h00301; wd1 = 8'hC3; req1 = 1'b1;
            wait_ack(1, STARVE_LIM, n);
            chk("t6_starve_bound", (n > 0) && (n <= STARVE_LIM), 1'b1);
            req1 = 1'b0;
            stop = 1'b1;
         end
      join
      repeat (W + 4) @(negedge clk);

      // Random traffic from both ports
      fork
         for (int t = 0; t < 120; t++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            we0 = 1'($urandom); wd0 = 8'($urandom);
            addr0 = ($urandom_range(0, 3) == 0) ? 19'($urandom) : 19'($urandom_range(0, 7));
            req0 = 1'b1;
            wait_ack(0, STARVE_LIM, n);
            chk("rand_p0_ack_in_bound", n > 0, 1'b1);
            req0 = 1'b0;
         end
         for (int t = 0; t < 120; t++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            we1 = 1'($urandom); wd1 = 8'($urandom);
            addr1 = ($urandom_range(0, 3) == 0) ? 19'($urandom) : 19'($urandom_range(0, 7));
            req1 = 1'b1;
            wait_ack(1, STARVE_LIM, n);
            chk("rand_p1_ack_in_bound", n > 0, 1'b1);
            req1 = 1'b0;
         end
      join
      repeat (W + 4) @(negedge clk);

      chk("min_write_to_read_gap_ge2", min_wr_rd_gap >= 2, 1'b1);
      chk("min_read_to_write_gap_ge1", min_rd_wr_gap >= 1, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
